// File: rtl/mult_seq_if.sv
// mult_seq_if: handshake and data bundle for the mult_seq sequential multiplier.
//   a, b         operands, sampled on the start edge
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   doMult       start request, level-sampled on every rising edge
//   busy         high while an operation is in progress
//   mult_done    one-cycle pulse when the product is valid
//   out_lo       product bits [WIDTH-1:0]
//   out_hi       product bits [2*WIDTH-1:WIDTH]
// The master modport is the requester; the slave modport is the multiplier.
interface mult_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             doMult;
  logic             busy;
  logic             mult_done;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;

  modport master (
    output a, b, signed_mode, doMult,
    input  busy, mult_done, out_lo, out_hi
  );

  modport slave (
    input  a, b, signed_mode, doMult,
    output busy, mult_done, out_lo, out_hi
  );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// Signed operands are reduced to magnitudes at start and the product is
// negated on the final edge.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mult_seq_if.slave (operands, mode, start, busy, done, product)
// Optional build macro: MULT_EARLY_TERM_EN -- finish RUN as soon as the
// remaining multiplier bits are all zero (minimum one RUN edge).
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        reset_n,
  mult_seq_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    out_q, out_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    acc_sum;
  logic             last;

  always_comb begin
    abs_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // mag_a is kept pre-shifted, so adding it is the same as adding
    // the original magnitude shifted by the iteration count.
    acc_sum = acc_q + (mag_b_q[0] ? mag_a_q : '0);

`ifdef MULT_EARLY_TERM_EN
    last = (cnt_q == CNT_W'(WIDTH - 1)) || ((mag_b_q >> 1) == '0);
`else
    last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.doMult) begin
          mag_a_d = PW'(abs_a);
          mag_b_d = abs_b;
          neg_d   = bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_sum;
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          out_d   = neg_q ? -acc_sum : acc_sum;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mult_done = done_q;
  assign bus.out_lo    = out_q[WIDTH-1:0];
  assign bus.out_hi    = out_q[PW-1:WIDTH];
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: self-checking bench for mult_seq (WIDTH=32) using a
// behavioural product/latency model and randomized operands.
module tb_mult_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(W)) bus();
  mult_seq #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [63:0] last_prod = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int ref_edges(input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] mb;
    int hb;
    mb = (s && b[31]) ? -b : b;
    hb = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) hb = i + 1;
    return (hb < 1) ? 1 : hb;
`else
    return W;
`endif
  endfunction

  // One operation; optionally pulse doMult and scramble inputs at RUN cycle `inject`.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input string tag, input int inject);
    int n;
    int exp_n;
    logic [63:0] exp;
    exp   = ref_prod(a, b, s);
    exp_n = ref_edges(b, s);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.signed_mode = s; bus.doMult = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    check({tag, "_hold"}, {bus.out_hi, bus.out_lo}, last_prod);
    @(negedge clk);
    bus.doMult = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == inject) begin
        bus.doMult = 1'b1; bus.a = ~a; bus.b = $urandom; bus.signed_mode = ~s;
      end else if (n == inject + 1) begin
        bus.doMult = 1'b0;
      end
      if (bus.mult_done) break;
    end
    bus.doMult = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(exp_n));
    check({tag, "_prod"}, {bus.out_hi, bus.out_lo}, exp);
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    last_prod = exp;
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 64'(bus.mult_done), 64'd0);
    check({tag, "_prod_hold"}, {bus.out_hi, bus.out_lo}, exp);
  endtask

  initial begin
    int cnt;
    int pulses;
    int prev;
    int busy_bad;
    int exp_n;
    logic [31:0] ra, rb;

    reset_n = 1'b0;
    bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0; bus.doMult = 1'b0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.mult_done), 64'd0);
    check("rst_out", {bus.out_hi, bus.out_lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(32'd2, 32'd5, 1'b0, "u_2x5", -10);
    run_op(32'h03, 32'h69, 1'b0, "u_3x69", -10);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "u_max", -10);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "s_m1", -10);
    run_op(32'hF0000000, 32'hF0000000, 1'b0, "u_f0", -10);
    run_op(32'hF0000000, 32'hF0000000, 1'b1, "s_f0", -10);
    run_op(32'h80000000, 32'h80000000, 1'b1, "s_min", -10);
    run_op(32'hFFFFFFFE, 32'd3, 1'b1, "s_m2x3", -10);
    run_op(32'h12345678, 32'd0, 1'b0, "u_bzero", -10);
    run_op(32'h12345678, 32'h9ABCDEF1, 1'b0, "u_inject", 10);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) rb = -rb;
      run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), -10);
    end

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    bus.a = 32'h1234; bus.b = 32'hFFFF0001; bus.signed_mode = 1'b0; bus.doMult = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.doMult = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.mult_done), 64'd0);
    check("arst_out", {bus.out_hi, bus.out_lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.mult_done || bus.busy) cnt++;
    end
    check("arst_quiet", 64'(cnt), 64'd0);
    last_prod = '0;

    // doMult held high: back-to-back operations
    exp_n = ref_edges(32'd5, 1'b0);
    @(negedge clk);
    bus.a = 32'd2; bus.b = 32'd5; bus.signed_mode = 1'b0; bus.doMult = 1'b1;
    @(posedge clk); #1;
    pulses = 0; prev = -1; busy_bad = 0;
    for (int cyc = 1; cyc < 400 && pulses < 3; cyc++) begin
      @(posedge clk); #1;
      if (bus.mult_done) begin
        pulses++;
        check($sformatf("b2b_period%0d", pulses), 64'(cyc - prev), 64'(exp_n + 1));
        check($sformatf("b2b_lo%0d", pulses), 64'(bus.out_lo), 64'h0A);
        check($sformatf("b2b_hi%0d", pulses), 64'(bus.out_hi), 64'h0);
        if (bus.busy) busy_bad++;
        prev = cyc;
      end else if (!bus.busy) begin
        busy_bad++;
      end
    end
    bus.doMult = 1'b0;
    check("b2b_pulses", 64'(pulses), 64'd3);
    check("b2b_busy", 64'(busy_bad), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
